// File: rtl/overflow_pkg.sv
// Shared constants for the overflow detector slice.
//   COUNT_W_DEFAULT : default width of the overflow event counter
//   COUNT_W_MIN/MAX : legal counter width range
//   sat_value(w)    : saturation value (all ones) of a w-bit counter
package overflow_pkg;

    localparam int unsigned COUNT_W_DEFAULT = 16;
    localparam int unsigned COUNT_W_MIN     = 2;
    localparam int unsigned COUNT_W_MAX     = 32;

    // Largest value a w-bit unsigned counter may hold; w=32 handled apart to avoid a 32-bit shift overflow.
    function automatic logic [31:0] sat_value(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   clr   : synchronous clear, wins over inc
//   inc   : increment request, ignored once saturated
//   count : registered count value
module sat_counter
    import overflow_pkg::*;
#(
    parameter int unsigned W = COUNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] SAT = W'(sat_value(W));

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then increment only below saturation so it never wraps.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != SAT)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/overflow.sv
// Two's-complement addition overflow detector with registered bookkeeping.
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   A, B      : sign bits of the two operands
//   sign      : sign bit of the computed sum
//   valid     : qualifies A/B/sign for the registered outputs
//   clr       : synchronous clear of sticky flag and counter (not of_q)
//   of        : combinational overflow indication
//   of_q      : of sampled on qualified cycles
//   of_sticky : set by any qualified overflow until clr/rst
//   of_count  : saturating count of qualified overflows
module overflow
    import overflow_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               B,
    input  logic               sign,
    input  logic               valid,
    input  logic               clr,
    output logic               of,
    output logic               of_q,
    output logic               of_sticky,
    output logic [COUNT_W-1:0] of_count
);

    logic of_reg_q;
    logic of_reg_d;
    logic sticky_q;
    logic sticky_d;
    logic qual_of;

    // Overflow only when operand signs agree and the sum sign departs from them.
    assign of      = (A ~^ B) & (A ^ sign);
    assign qual_of = valid & of;

    // Next state for sampled flag and sticky flag; clr leaves the sampled flag alone.
    always_comb begin
        of_reg_d = of_reg_q;
        sticky_d = sticky_q;
        if (valid) begin
            of_reg_d = of;
        end
        if (clr) begin
            sticky_d = 1'b0;
        end else if (qual_of) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            of_reg_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            of_reg_q <= of_reg_d;
            sticky_q <= sticky_d;
        end
    end

    sat_counter #(
        .W(COUNT_W)
    ) u_count (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (qual_of),
        .count(of_count)
    );

    assign of_q      = of_reg_q;
    assign of_sticky = sticky_q;

endmodule

// File: tb/tb_overflow.sv
// Self-checking bench for overflow: default-width and 2-bit-counter instances share stimulus.
module tb_overflow;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        A     = 1'b0;
    logic        B     = 1'b0;
    logic        sign  = 1'b0;
    logic        valid = 1'b0;
    logic        clr   = 1'b0;

    logic        of16, ofq16, st16;
    logic [15:0] cnt16;
    logic        of2, ofq2, st2;
    logic [1:0]  cnt2;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: sampled flag, sticky flag, and event counts per instance.
    bit m_q;
    bit m_st;
    int m_c16;
    int m_c2;

    overflow dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .sign(sign), .valid(valid), .clr(clr),
        .of(of16), .of_q(ofq16), .of_sticky(st16), .of_count(cnt16)
    );

    overflow #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .sign(sign), .valid(valid), .clr(clr),
        .of(of2), .of_q(ofq2), .of_sticky(st2), .of_count(cnt2)
    );

    always #5 clk = ~clk;

    // Overflow from the arithmetic rule: same operand signs, different result sign.
    function automatic bit ref_of(input bit a, input bit b, input bit s);
        return (a == b) && (s != a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".of"},      32'(of16),  32'(ref_of(A, B, sign)));
        check({tag, ".of2"},     32'(of2),   32'(ref_of(A, B, sign)));
        check({tag, ".of_q"},    32'(ofq16), 32'(m_q));
        check({tag, ".of_q2"},   32'(ofq2),  32'(m_q));
        check({tag, ".sticky"},  32'(st16),  32'(m_st));
        check({tag, ".sticky2"}, 32'(st2),   32'(m_st));
        check({tag, ".cnt16"},   32'(cnt16), 32'(m_c16));
        check({tag, ".cnt2"},    32'(cnt2),  32'(m_c2));
    endtask

    task automatic model_reset();
        m_q   = 1'b0;
        m_st  = 1'b0;
        m_c16 = 0;
        m_c2  = 0;
    endtask

    // Drive inputs (called just after an edge), take one edge, update model, sample #1 later.
    task automatic step(input bit a, input bit b, input bit s, input bit v, input bit c);
        A = a; B = b; sign = s; valid = v; clr = c;
        @(posedge clk);
        if (!rst) begin
            if (v) m_q = ref_of(a, b, s);
            if (c) begin
                m_st  = 1'b0;
                m_c16 = 0;
                m_c2  = 0;
            end else if (v && ref_of(a, b, s)) begin
                m_st  = 1'b1;
                m_c16 = (m_c16 + 1 > 65535) ? 65535 : m_c16 + 1;
                m_c2  = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
            end
        end
        #1;
    endtask

    initial begin
        logic [2:0] combo;

        // Asynchronous reset asserted between edges takes effect immediately.
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("reset_async");

        // Detector keeps following its inputs while in reset; full 8-way sweep.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            A = combo[2]; B = combo[1]; sign = combo[0];
            #1;
            check($sformatf("sweep_%0d%0d%0d", combo[2], combo[1], combo[0]),
                  32'(of16), 32'((combo == 3'b001) || (combo == 3'b110)));
        end

        // Qualified overflows during reset must be ignored.
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_all("in_reset");

        rst = 1'b0;

        // Directed truth-table points, no clock edge between set and check.
        A = 1'b0; B = 1'b0; sign = 1'b0; #1; check("tt_000", 32'(of16), 32'd0);
        A = 1'b0; B = 1'b0; sign = 1'b1; #1; check("tt_001", 32'(of16), 32'd1);
        A = 1'b1; B = 1'b1; sign = 1'b1; #1; check("tt_111", 32'(of16), 32'd0);
        A = 1'b1; B = 1'b1; sign = 1'b0; #1; check("tt_110", 32'(of16), 32'd1);

        // Three qualified overflows after reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("three_cnt",    32'(cnt16), 32'd3);
        check("three_sticky", 32'(st16),  32'd1);
        check("three_q",      32'(ofq16), 32'd1);
        check_all("three");

        // Unqualified overflows leave registered state alone.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check_all("hold_of");
        end
        check("hold_cnt", 32'(cnt16), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_q", 32'(ofq16), 32'd1);

        // Qualified non-overflow loads 0 into of_q; count and sticky stay.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("load0_q", 32'(ofq16), 32'd0);
        check_all("load0");

        // clr beats a simultaneous qualified overflow; of_q still samples.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_cnt",    32'(cnt16), 32'd0);
        check("clr_sticky", 32'(st16),  32'd0);
        check("clr_q",      32'(ofq16), 32'd1);
        check_all("clr");

        // Five overflows saturate the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sat_cnt2",  32'(cnt2),  32'd3);
        check("sat_cnt16", 32'(cnt16), 32'd5);
        check_all("sat");

        // Mid-cycle reset clears everything at once.
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_cnt",    32'(cnt16), 32'd0);
        check("midrst_cnt2",   32'(cnt2),  32'd0);
        check("midrst_sticky", 32'(st16),  32'd0);
        check("midrst_q",      32'(ofq16), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_all("post_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
